// File: rtl/sym_pkg.sv
// Shared definitions for the symmetric pair generator and the downstream
// axis-transform stage.
//   sym_state_e : control state (FILL = collecting a frame, EMIT = streaming pairs)
//   sym_width   : sample width helper, returns integer bits + fractional bits
package sym_pkg;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } sym_state_e;

  function automatic int sym_width(input int m, input int n);
    return m + n;
  endfunction

endpackage

// File: rtl/sym_pair_bank.sv
// One LEN x W sample bank with a single write port and two combinational read
// ports returning the mirrored pair (x[i], x[LEN-1-i]).
//   clk    : clock
//   we     : write enable
//   waddr  : write index 0..LEN-1
//   wdata  : sample to store
//   ridx   : pair index 0..LEN/2-1
//   f_data : x[ridx]
//   s_data : x[LEN-1-ridx]
// Storage is deliberately not reset; contents are only read after a full frame
// has been written.
module sym_pair_bank #(
  parameter int W   = 12,
  parameter int LEN = 8,
  localparam int AW = $clog2(LEN),
  localparam int IW = $clog2(LEN / 2)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [W-1:0]  wdata,
  input  logic [IW-1:0]        ridx,
  output logic signed [W-1:0]  f_data,
  output logic signed [W-1:0]  s_data
);

  logic signed [W-1:0] mem [LEN];
  logic [AW-1:0]       f_addr;
  logic [AW-1:0]       s_addr;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // LEN is a power of two, so LEN-1-i is the bitwise complement of i.
  assign f_addr = {1'b0, ridx};
  assign s_addr = ~f_addr;

  assign f_data = mem[f_addr];
  assign s_data = mem[s_addr];

endmodule

// File: rtl/sym_pair_gen.sv
// Symmetric pair generator: buffers a frame of LEN signed fixed-point samples
// and emits the pairs (x[i], x[LEN-1-i]) for i = 0..LEN/2-1 with valid/ready
// handshakes on both sides. Samples pass bit-exact.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake
//   in_data             : signed sample, frame order x[0]..x[LEN-1]
//   out_valid/out_ready : output handshake
//   f_out, s_out        : pair elements x[i], x[LEN-1-i]
//   out_idx             : pair index i
//   out_last            : high with the final pair of a frame
// Build option SYM_PAIR_PINGPONG_EN: two banks so a new frame can be collected
// while the previous one is emitted. Default build uses a single bank.
module sym_pair_gen
  import sym_pkg::*;
#(
  parameter int M   = 4,
  parameter int N   = 8,
  parameter int LEN = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [sym_width(M, N)-1:0]   in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [sym_width(M, N)-1:0]   f_out,
  output logic signed [sym_width(M, N)-1:0]   s_out,
  output logic [$clog2(LEN / 2)-1:0]          out_idx,
  output logic                                out_last
);

  localparam int W  = sym_width(M, N);
  localparam int AW = $clog2(LEN);
  localparam int IW = $clog2(LEN / 2);
  localparam logic [AW-1:0] LAST_W = AW'(LEN - 1);
  localparam logic [IW-1:0] LAST_I = IW'(LEN / 2 - 1);

  logic [AW-1:0] widx_reg;
  logic [IW-1:0] ridx_reg;
  logic          in_fire;
  logic          out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_idx  = ridx_reg;
  assign out_last = out_valid && (ridx_reg == LAST_I);

`ifdef SYM_PAIR_PINGPONG_EN

  // full_reg[b] marks bank b as holding a complete frame awaiting emission.
  // Fill and emit selectors both toggle per frame, so frames leave in arrival
  // order. A bank is never set and cleared in the same cycle: setting needs
  // the fill bank empty, clearing needs the emit bank full.
  logic [1:0]          full_reg;
  logic                fill_sel_reg;
  logic                emit_sel_reg;
  sym_state_e          emit_state;
  logic signed [W-1:0] f_bank [2];
  logic signed [W-1:0] s_bank [2];

  assign emit_state = full_reg[emit_sel_reg] ? EMIT : FILL;
  assign in_ready   = !full_reg[fill_sel_reg];
  assign out_valid  = (emit_state == EMIT);
  assign f_out      = f_bank[emit_sel_reg];
  assign s_out      = s_bank[emit_sel_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg     <= '0;
      fill_sel_reg <= 1'b0;
      emit_sel_reg <= 1'b0;
      widx_reg     <= '0;
      ridx_reg     <= '0;
    end else begin
      if (in_fire) begin
        widx_reg <= widx_reg + 1'b1;
        if (widx_reg == LAST_W) begin
          full_reg[fill_sel_reg] <= 1'b1;
          fill_sel_reg           <= ~fill_sel_reg;
        end
      end
      if (out_fire) begin
        ridx_reg <= ridx_reg + 1'b1;
        if (ridx_reg == LAST_I) begin
          full_reg[emit_sel_reg] <= 1'b0;
          emit_sel_reg           <= ~emit_sel_reg;
        end
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    sym_pair_bank #(
      .W   (W),
      .LEN (LEN)
    ) u_bank (
      .clk    (clk),
      .we     (in_fire && (fill_sel_reg == 1'(gi))),
      .waddr  (widx_reg),
      .wdata  (in_data),
      .ridx   (ridx_reg),
      .f_data (f_bank[gi]),
      .s_data (s_bank[gi])
    );
  end

`else

  sym_state_e state_reg;
  sym_state_e state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FILL;
      widx_reg  <= '0;
      ridx_reg  <= '0;
    end else begin
      state_reg <= state_next;
      // Both indices wrap naturally because LEN is a power of two.
      if (in_fire) begin
        widx_reg <= widx_reg + 1'b1;
      end
      if (out_fire) begin
        ridx_reg <= ridx_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      FILL: begin
        in_ready = 1'b1;
        if (in_fire && (widx_reg == LAST_W)) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_fire && (ridx_reg == LAST_I)) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  sym_pair_bank #(
    .W   (W),
    .LEN (LEN)
  ) u_bank (
    .clk    (clk),
    .we     (in_fire),
    .waddr  (widx_reg),
    .wdata  (in_data),
    .ridx   (ridx_reg),
    .f_data (f_out),
    .s_data (s_out)
  );

`endif

endmodule

// File: tb/tb_sym_pair_gen.sv
// Directed self-checking bench for sym_pair_gen with default parameters
// (M=4, N=8 -> 12-bit samples, LEN=8).
module tb_sym_pair_gen;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [11:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [11:0] f_out;
  logic signed [11:0] s_out;
  logic [1:0]         out_idx;
  logic               out_last;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sym_pair_gen dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f_out     (f_out),
    .s_out     (s_out),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  // Advance one clock; outputs are observed and inputs driven 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drive eight samples back-to-back; the block is in FILL, so each is taken.
  task automatic send_frame(input logic signed [11:0] d [8]);
    for (int k = 0; k < 8; k++) begin
      in_data  = d[k];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_idx !== 2'd0) $display("FAIL reset_out_idx: got %0d want 0", out_idx);
    else pass_cnt++;
    total_cnt++;
    if (out_last !== 1'b0) $display("FAIL reset_out_last: got %0b want 0", out_last);
    else pass_cnt++;
    $display("reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);
  endtask

  // Frame 1..8 with out_ready=1; junk offered during EMIT must be ignored.
  task automatic test_basic();
    logic signed [11:0] d [8];
    logic signed [11:0] ef, es;
    for (int k = 0; k < 8; k++) d[k] = 12'(k + 1);
    out_ready = 1'b1;
    send_frame(d);
    in_valid = 1'b1;
    in_data  = 12'sd99;
    for (int k = 0; k < 4; k++) begin
      ef = 12'(k + 1);
      es = 12'(8 - k);
      total_cnt++;
      if (out_valid !== 1'b1 || f_out !== ef || s_out !== es || out_idx !== 2'(k) ||
          out_last !== (k == 3) || in_ready !== 1'b0)
        $display("FAIL basic_pair%0d: got v=%0b (%0d,%0d) idx=%0d last=%0b rdy=%0b want v=1 (%0d,%0d) idx=%0d last=%0b rdy=0",
                 k, out_valid, f_out, s_out, out_idx, out_last, in_ready, ef, es, k, k == 3);
      else pass_cnt++;
      $display("basic: pair %0d (%0d,%0d) last=%0b", out_idx, f_out, s_out, out_last);
      tick();
    end
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL basic_back_to_fill: got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  // Stall pair 1 for three cycles; no reset, so this also shows the junk
  // offered during the previous EMIT did not shift the write index.
  task automatic test_backpressure();
    logic signed [11:0] d [8];
    for (int k = 0; k < 8; k++) d[k] = 12'(k + 1);
    out_ready = 1'b1;
    send_frame(d);
    total_cnt++;
    if (out_valid !== 1'b1 || f_out !== 12'sd1 || s_out !== 12'sd8)
      $display("FAIL bp_pair0: got v=%0b (%0d,%0d) want v=1 (1,8)", out_valid, f_out, s_out);
    else pass_cnt++;
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || f_out !== 12'sd2 || s_out !== 12'sd7 || out_idx !== 2'd1)
        $display("FAIL bp_hold%0d: got v=%0b (%0d,%0d) idx=%0d want v=1 (2,7) idx=1",
                 c, out_valid, f_out, s_out, out_idx);
      else pass_cnt++;
      $display("backpressure: stall %0d pair %0d (%0d,%0d)", c, out_idx, f_out, s_out);
      tick();
    end
    out_ready = 1'b1;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || f_out !== 12'sd3 || s_out !== 12'sd6 || out_idx !== 2'd2)
      $display("FAIL bp_resume: got v=%0b (%0d,%0d) idx=%0d want v=1 (3,6) idx=2",
               out_valid, f_out, s_out, out_idx);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_end: got v=%0b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_extremes();
    logic signed [11:0] d [8];
    logic signed [11:0] ef [4];
    logic signed [11:0] es [4];
    d  = '{-12'sd2048, 12'sd2047, -12'sd30, 12'sd80, -12'sd45, -12'sd20, 12'sd0, -12'sd100};
    ef = '{-12'sd2048, 12'sd2047, -12'sd30, 12'sd80};
    es = '{-12'sd100, 12'sd0, -12'sd20, -12'sd45};
    do_reset();
    out_ready = 1'b1;
    send_frame(d);
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || f_out !== ef[k] || s_out !== es[k])
        $display("FAIL extreme_pair%0d: got v=%0b (%0d,%0d) want v=1 (%0d,%0d)",
                 k, out_valid, f_out, s_out, ef[k], es[k]);
      else pass_cnt++;
      $display("extremes: pair %0d (%0d,%0d)", k, f_out, s_out);
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic signed [11:0] d [8];
    logic signed [11:0] ef, es;
    for (int k = 0; k < 8; k++) d[k] = 12'(k + 21);
    do_reset();
    out_ready = 1'b1;
    send_frame(d);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midrst_flush: got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready);
    else pass_cnt++;
    for (int k = 0; k < 8; k++) d[k] = 12'(k + 11);
    send_frame(d);
    for (int k = 0; k < 4; k++) begin
      ef = 12'(11 + k);
      es = 12'(18 - k);
      total_cnt++;
      if (out_valid !== 1'b1 || f_out !== ef || s_out !== es || out_idx !== 2'(k))
        $display("FAIL midrst_pair%0d: got v=%0b (%0d,%0d) idx=%0d want v=1 (%0d,%0d) idx=%0d",
                 k, out_valid, f_out, s_out, out_idx, ef, es, k);
      else pass_cnt++;
      $display("reset_mid: pair %0d (%0d,%0d)", out_idx, f_out, s_out);
      tick();
    end
  endtask

  // 16 samples offered every cycle, downstream always ready.
  task automatic test_back_to_back();
    int sent = 0;
    int pairs = 0;
    int stall = 0;
    int exp_stall;
    logic signed [11:0] ef, es;
`ifdef SYM_PAIR_PINGPONG_EN
    exp_stall = 0;
`else
    exp_stall = 4;
`endif
    do_reset();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && pairs < 8; cyc++) begin
      logic in_fire;
      in_valid = (sent < 16);
      in_data  = 12'(sent + 1);
      if (sent < 16 && !in_ready) stall++;
      in_fire = in_valid && in_ready;
      if (out_valid) begin
        ef = 12'((pairs / 4) * 8 + (pairs % 4) + 1);
        es = 12'((pairs / 4) * 8 + 8 - (pairs % 4));
        total_cnt++;
        if (f_out !== ef || s_out !== es || out_idx !== 2'(pairs % 4) || out_last !== ((pairs % 4) == 3))
          $display("FAIL stream_pair%0d: got (%0d,%0d) idx=%0d last=%0b want (%0d,%0d) idx=%0d last=%0b",
                   pairs, f_out, s_out, out_idx, out_last, ef, es, pairs % 4, (pairs % 4) == 3);
        else pass_cnt++;
        $display("stream: pair %0d (%0d,%0d)", pairs, f_out, s_out);
        pairs++;
      end
      tick();
      if (in_fire) sent++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (pairs != 8) $display("FAIL stream_pair_count: got %0d want 8", pairs);
    else pass_cnt++;
    total_cnt++;
    if (stall != exp_stall) $display("FAIL stream_stall_cycles: got %0d want %0d", stall, exp_stall);
    else pass_cnt++;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_extremes();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sym_pair_gen.md
SYM_PAIR_GEN -- requirements
Module: sym_pair_gen

Interface
REQ-001 SHALL have parameter M, default 4, integer bits of the signed fixed-point sample.
REQ-002 SHALL have parameter N, default 8, fractional bits; sample width W = M+N.
REQ-003 SHALL have parameter LEN, default 8, frame length in samples; even, power of 2, >= 4.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream sample valid.
REQ-007 SHALL have port in_ready  output  1  block accepts sample this cycle.
REQ-008 SHALL have port in_data  input  W signed  sample, frame order x[0]..x[LEN-1].
REQ-009 SHALL have port out_valid  output  1  pair valid to downstream axis-transform stage.
REQ-010 SHALL have port out_ready  input  1  downstream accepts pair.
REQ-011 SHALL have port f_out  output  W signed  first pair element x[i].
REQ-012 SHALL have port s_out  output  W signed  mirrored element x[LEN-1-i].
REQ-013 SHALL have port out_idx  output  clog2(LEN/2)  pair index i.
REQ-014 SHALL have port out_last  output  1  high with pair i = LEN/2-1.

Function
REQ-015 Transfer SHALL occur only on cycles where valid and ready are both high, independently per side.
REQ-016 Accepted samples SHALL be written at write index 0..LEN-1, incrementing per input transfer, wrapping to 0 after LEN-1.
REQ-017 Control SHALL be an FSM with states FILL and EMIT.
REQ-018 FILL: in_ready=1, out_valid=0; transfer of sample LEN-1 in cycle t SHALL move to EMIT with out_valid=1 at t+1 showing pair 0.
REQ-019 EMIT: in_ready=0, out_valid=1; each output transfer SHALL advance i by 1; transfer with out_last=1 SHALL return to FILL next cycle.
REQ-020 f_out, s_out, out_idx, out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 Samples SHALL pass bit-exact; no arithmetic, rounding or saturation (-2048 and 2047 for W=12 unchanged).
REQ-022 in_valid while in_ready=0 SHALL be ignored; data not consumed.

Reset
REQ-023 rst=1 at an edge SHALL set FILL, write index 0, read index 0, out_valid=0, out_idx=0, out_last=0; in_ready=1 from the first cycle after rst deasserts.
REQ-024 Reset mid-FILL or mid-EMIT SHALL discard the partial frame; no pair of it emitted afterwards.
REQ-025 Buffer storage SHALL not be reset; f_out/s_out are don't-care while out_valid=0.

Configuration
REQ-026 Macro SYM_PAIR_PINGPONG_EN SHALL select double buffering.
REQ-027 Without SYM_PAIR_PINGPONG_EN: one LEN-entry bank; behaviour exactly REQ-017..REQ-019.
REQ-028 With SYM_PAIR_PINGPONG_EN: two banks; input fills one while the other emits; in_ready=0 only when the fill bank is full and the emit bank still has pairs pending; completing a frame while the emit bank is idle SHALL make out_valid=1 next cycle; frames emitted in arrival order.

Structure
REQ-029 Package sym_pkg SHALL hold the state enum (FILL, EMIT) and a width helper returning M+N; shared with the axis-transform stage.
REQ-030 Sub-module sym_pair_bank SHALL implement one LEN x W register bank, one write port, two combinational read ports (i, LEN-1-i); instantiated once, or twice under SYM_PAIR_PINGPONG_EN.

Verification
REQ-031 LEN=8, samples 1..8 back-to-back, out_ready=1 -> pairs (1,8),(2,7),(3,6),(4,5), out_idx 0..3, out_last on pair 3, first out_valid one cycle after sample 8.
REQ-032 Pair 1 shown, out_ready=0 for 3 cycles -> (2,7), out_idx=1 held 3 cycles; emission resumes with (3,6).
REQ-033 Frame -2048,2047,-30,80,-45,-20,0,-100 -> pairs (-2048,-100),(2047,0),(-30,-20),(80,-45), bit-exact.
REQ-034 rst asserted after 2 pairs emitted -> out_valid=0 next cycle; new frame 11..18 yields (11,18) first, no stale pairs.
REQ-035 16 samples, in_valid=1 every cycle, out_ready=1 -> without macro in_ready low 4 cycles after sample 8; with SYM_PAIR_PINGPONG_EN in_ready never drops and all 8 pairs arrive in order.
